mem_march_tester: RTL

Parametrised on-chip memory self-test engine that generalises the team's per-peripheral SRAM/flash test benches into synthesizable RTL. It drives a generic single-port request/acknowledge memory port and writes and verifies a configurable address window. It runs either an address-as-data pattern or a March C- sequence, and reports pass/fail and an error count. It sits between the CPU's peripheral bus and the SRAM/flash controllers, so the board can self-test memory without a host bench.

---
 rtl/mem_march_tester_pkg.sv | 27 ++
 rtl/mem_march_tester_march_seq.sv | 35 +++
 rtl/mem_march_tester.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_march_tester_pkg.sv
// Shared types and March C- element table for the memory self-test engine.
// Pure declarations; no logic, no latency, no flow control.
package mem_march_tester_pkg;

    typedef enum logic {
        MARCH_ADDR_PAT = 1'b0,
        MARCH_CMINUS   = 1'b1
    } MarchMode_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUBBLE,
        DONE
    } MarchState_t;

    localparam logic [2:0] LAST_ELEM_ADDR_PAT = 3'd1;
    localparam logic [2:0] LAST_ELEM_CMINUS   = 3'd5;

    // Bit e of each mask describes March element M<e>; op1 is always a write.
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
    localparam logic [7:0] ELEM_DESC    = 8'b0001_1000;
    localparam logic [7:0] ELEM_OP0_WE  = 8'b0000_0001;
    localparam logic [7:0] ELEM_OP0_POL = 8'b0001_0100;
    localparam logic [7:0] ELEM_OP1_POL = 8'b0000_1010;

endpackage

// File: rtl/mem_march_tester_march_seq.sv
// Decodes (element, op) into the operation type, data polarity, direction and end flags.
// Purely combinational, zero latency; no flow control of its own.
module mem_march_tester_march_seq
    import mem_march_tester_pkg::*;
(
    input  MarchMode_t mode,
    input  logic [2:0] elem,
    input  logic       op,
    output logic       we,
    output logic       pol,
    output logic       desc,
    output logic       last_op,
    output logic       last_elem
);

    always_comb begin
        we        = 1'b0;
        pol       = 1'b0;
        desc      = 1'b0;
        last_op   = 1'b1;
        last_elem = 1'b0;
        if (mode == MARCH_ADDR_PAT) begin
            // element 0 writes the address pattern, element 1 reads it back
            we        = (elem == 3'd0);
            last_elem = (elem == LAST_ELEM_ADDR_PAT);
        end else begin
            desc      = ELEM_DESC[elem];
            last_op   = op || !ELEM_TWO_OPS[elem];
            last_elem = (elem == LAST_ELEM_CMINUS);
            we        = op || ELEM_OP0_WE[elem];
            pol       = op ? ELEM_OP1_POL[elem] : ELEM_OP0_POL[elem];
        end
    end

endmodule

// File: rtl/mem_march_tester.sv
// Memory self-test: address-pattern or March C- over a window; optional first-fail log (MEM_MARCH_TESTER_FAIL_LOG_EN).
// Latency: 2 cycles per op at zero wait, +1 per memory wait state; done one cycle after the last ack.
// Backpressure: holds mem_req and its command until mem_ack; start ignored while busy.
module mem_march_tester
    import mem_march_tester_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    MarchState_t           state, state_nxt;
    MarchMode_t            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q, idx, offset;
    logic [2:0]            elem;
    logic                  op;
    logic                  any_err;
    logic                  seq_we, seq_pol, seq_desc, seq_last_op, seq_last_elem;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  acked, mismatch, final_op;

    mem_march_tester_march_seq u_seq (
        .mode      (mode_q),
        .elem      (elem),
        .op        (op),
        .we        (seq_we),
        .pol       (seq_pol),
        .desc      (seq_desc),
        .last_op   (seq_last_op),
        .last_elem (seq_last_elem)
    );

    always_comb begin
        offset   = seq_desc ? (count_q - CNT_ONE - idx) : idx;
        exp_data = (mode_q == MARCH_CMINUS) ? {DATA_WIDTH{seq_pol}} : DATA_WIDTH'(offset);
        acked    = (state == ISSUE) && mem_ack;
        mismatch = acked && !seq_we && (mem_rdata != exp_data);
        final_op = seq_last_op && seq_last_elem && (idx == count_q - CNT_ONE);
    end

    // The DONE cycle doubles as the bubble after the final ack.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = base_q + ADDR_WIDTH'(offset);
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (word_count == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = seq_we;
                mem_wdata = seq_we ? exp_data : '0;
                if (mem_ack) state_nxt = final_op ? DONE : BUBBLE;
            end
            BUBBLE: begin
                busy      = 1'b1;
                state_nxt = ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MARCH_ADDR_PAT;
            base_q    <= '0;
            count_q   <= '0;
            idx       <= '0;
            elem      <= '0;
            op        <= 1'b0;
            any_err   <= 1'b0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    mode_q    <= MarchMode_t'(mode);
                    base_q    <= base_addr;
                    count_q   <= word_count;
                    idx       <= '0;
                    elem      <= '0;
                    op        <= 1'b0;
                    any_err   <= 1'b0;
                    err_count <= '0;
                    pass      <= (word_count == '0);
                end
                ISSUE: if (mem_ack) begin
                    if (mismatch) begin
                        any_err <= 1'b1;
                        if (err_count != {ERR_WIDTH{1'b1}}) err_count <= err_count + ERR_WIDTH'(1);
                    end
                    if (final_op) pass <= !(any_err || mismatch);
                end
                BUBBLE: begin
                    if (!seq_last_op) begin
                        op <= 1'b1;
                    end else begin
                        op <= 1'b0;
                        if (idx == count_q - CNT_ONE) begin
                            idx  <= '0;
                            elem <= elem + 3'd1;
                        end else begin
                            idx <= idx + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_MARCH_TESTER_FAIL_LOG_EN
    logic                  fail_v_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_act_q;

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            fail_v_q    <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else if (mismatch && !fail_v_q) begin
            fail_v_q    <= 1'b1;
            fail_addr_q <= mem_addr;
            fail_exp_q  <= exp_data;
            fail_act_q  <= mem_rdata;
        end
    end

    assign fail_valid    = fail_v_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
`else
    assign fail_valid    = 1'b0;
    assign fail_addr     = '0;
    assign fail_expected = '0;
    assign fail_actual   = '0;
`endif

endmodule
